// File: rtl/vproc.sv
// vproc: self-sequencing bus-master node for system-level benches.
// After reset it runs a fixed program: it burst-writes a pattern, patches one
// byte, burst-reads the region back and compares it, then writes the error
// count to an end-of-test address. Rising interrupts are serviced in the gaps
// between transactions by a single status write to IRQ_ADDR.
//
// Ports:
//   Clk, Reset      clock (rising edge) and asynchronous active-high reset
//   Addr, WE, RD    transaction address and write/read strobes
//   BE, DataOut     byte enables (bit n covers DataOut[8n+7:8n]) and write data
//   Burst           beat count of the current transaction (0 when idle)
//   BurstFirst/Last first / last beat markers
//   DataIn          read data, sampled when RDAck is seen
//   WRAck, RDAck    beat acknowledges for WE and RD respectively
//   Interrupt       level interrupt inputs, rising edges are latched
//   Update          toggles after every completed transaction
//   UpdateResponse  bench echo of Update; gates the next transaction
//   Node            node id, low 16 bits form the data pattern prefix
module vproc #(
    parameter int unsigned INT_WIDTH       = 3,
    parameter int unsigned NODE_WIDTH      = 32,
    parameter int unsigned BURST_ADDR_INCR = 1,
    parameter bit          DISABLE_DELTA   = 1'b0,
    parameter logic [31:0] BASE_ADDR       = 32'hA000_0000,
    parameter int unsigned NUM_WORDS       = 16,
    parameter logic [31:0] IRQ_ADDR        = 32'hC000_0000,
    parameter logic [31:0] END_ADDR        = 32'hB000_0000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    output logic [31:0]           Addr,
    output logic                  WE,
    output logic                  RD,
    output logic [3:0]            BE,
    output logic [11:0]           Burst,
    output logic                  BurstFirst,
    output logic                  BurstLast,
    output logic [31:0]           DataOut,
    input  logic [31:0]           DataIn,
    input  logic                  WRAck,
    input  logic                  RDAck,
    input  logic [INT_WIDTH-1:0]  Interrupt,
    output logic                  Update,
    input  logic                  UpdateResponse,
    input  logic [NODE_WIDTH-1:0] Node
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_WBURST,
        S_BYTEW,
        S_RBURST,
        S_ENDW,
        S_IRQ,
        S_DONE
    } state_t;

    localparam logic [11:0] NUM_BEATS = 12'(NUM_WORDS);
    localparam logic [11:0] LAST_BEAT = 12'(NUM_WORDS - 1);

    state_t                 state;
    state_t                 next_state;
    state_t                 next_prog;   // program transaction to start at the next gap
    logic [11:0]            beat;
    logic [31:0]            addr;
    logic [15:0]            errcnt;
    logic [15:0]            irq_k;
    logic                   update;
    logic [INT_WIDTH-1:0]   int_q;
    logic [INT_WIDTH-1:0]   pending;
    logic [INT_WIDTH-1:0]   clr_mask;
    logic [15:0]            pend_k;
    logic                   pend_any;
    logic                   ack;
    logic                   last_beat;
    logic                   go;
    logic [15:0]            p;
    logic [31:0]            rd_exp;
    logic                   unused_node;

    assign p           = Node[15:0];
    assign unused_node = ^Node;
    assign Update      = update;
    assign last_beat   = (beat == LAST_BEAT);
    assign go          = DISABLE_DELTA || (UpdateResponse == update);
    // Beat 0 was byte-patched after the burst write, so its low half reads back as 00EE.
    assign rd_exp      = (beat == '0) ? {p, 16'h00EE} : {p, 4'h0, beat};

    // Highest pending interrupt wins; clear mask targets the one being serviced.
    always_comb begin
        pend_k   = '0;
        pend_any = |pending;
        clr_mask = '0;
        for (int unsigned i = 0; i < INT_WIDTH; i++) begin
            if (pending[i]) begin
                pend_k = 16'(i);
            end
            clr_mask[i] = (state == S_IRQ) && ack && (irq_k == 16'(i));
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        Addr       = '0;
        WE         = 1'b0;
        RD         = 1'b0;
        BE         = '0;
        Burst      = '0;
        BurstFirst = 1'b0;
        BurstLast  = 1'b0;
        DataOut    = '0;
        next_state = state;
        case (state)
            S_WBURST, S_RBURST: begin
                WE         = (state == S_WBURST);
                RD         = (state == S_RBURST);
                Addr       = addr;
                BE         = 4'hF;
                DataOut    = (state == S_WBURST) ? {p, 4'h0, beat} : '0;
                Burst      = NUM_BEATS;
                BurstFirst = (beat == '0);
                BurstLast  = last_beat;
            end
            S_BYTEW, S_ENDW, S_IRQ: begin
                WE         = 1'b1;
                Addr       = addr;
                BE         = (state == S_BYTEW) ? 4'b0001 : 4'hF;
                Burst      = 12'd1;
                BurstFirst = 1'b1;
                BurstLast  = 1'b1;
                if (state == S_BYTEW) begin
                    DataOut = 32'h0000_00EE;
                end else if (state == S_ENDW) begin
                    DataOut = {16'h0000, errcnt};
                end else begin
                    DataOut = {16'h1A00, irq_k};
                end
            end
            default: ;
        endcase

        ack = (WE && WRAck) || (RD && RDAck);

        case (state)
            S_IDLE:   next_state = S_GAP;
            S_GAP:    if (go) next_state = pend_any ? S_IRQ : next_prog;
            S_WBURST: if (ack && last_beat) next_state = S_GAP;
            S_RBURST: if (ack && last_beat) next_state = S_GAP;
            S_BYTEW:  if (ack) next_state = S_GAP;
            S_IRQ:    if (ack) next_state = S_GAP;
            S_ENDW:   if (ack) next_state = S_DONE;
            default:  next_state = S_DONE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            next_prog <= S_WBURST;
            beat      <= '0;
            addr      <= '0;
            errcnt    <= '0;
            irq_k     <= '0;
            update    <= 1'b0;
            int_q     <= '0;
            pending   <= '0;
        end else begin
            // Edge detection runs every cycle, including mid-beat; frozen once done.
            if (state != S_DONE) begin
                int_q   <= Interrupt;
                pending <= (pending | (Interrupt & ~int_q)) & ~clr_mask;
            end
            case (state)
                S_GAP: begin
                    if (go) begin
                        if (pend_any) begin
                            irq_k <= pend_k;
                            addr  <= IRQ_ADDR;
                        end else begin
                            beat <= '0;
                            addr <= (next_prog == S_ENDW) ? END_ADDR : BASE_ADDR;
                        end
                    end
                end
                S_WBURST, S_RBURST: begin
                    if (ack) begin
                        if ((state == S_RBURST) && (DataIn != rd_exp) && (errcnt != '1)) begin
                            errcnt <= errcnt + 16'd1;
                        end
                        if (last_beat) begin
                            update    <= ~update;
                            next_prog <= (state == S_WBURST) ? S_BYTEW : S_ENDW;
                        end else begin
                            beat <= beat + 12'd1;
                            addr <= addr + BURST_ADDR_INCR;
                        end
                    end
                end
                S_BYTEW: begin
                    if (ack) begin
                        update    <= ~update;
                        next_prog <= S_RBURST;
                    end
                end
                S_ENDW, S_IRQ: begin
                    if (ack) begin
                        update <= ~update;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vproc.sv
// Self-checking bench for vproc: a memory-backed bus responder with a
// programmable ack delay, a transaction logger and a reference model that
// builds the expected beat list directly from the program description.
`define CHK(NAME, GOT, EXP) \
    begin \
        checks++; \
        assert ((GOT) === (EXP)) passes++; \
        else $error("FAIL %s got %h exp %h", NAME, (GOT), (EXP)); \
    end

module tb_vproc;

    localparam int          NW        = 4;
    localparam int          INCR      = 4;
    localparam logic [31:0] BASE      = 32'hA000_0000;
    localparam logic [31:0] IRQA      = 32'hC000_0000;
    localparam logic [31:0] ENDA      = 32'hB000_0000;
    localparam logic [31:0] NODE_ID   = 32'h5A5A_0001;
    localparam logic [15:0] P         = 16'h0001;
    localparam logic [31:0] FLIP      = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic        rd;
        logic [3:0]  be;
        logic [31:0] data;
        logic [11:0] burst;
        logic        first;
        logic        last;
        logic [7:0]  hold;
    } beat_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Addr;
    logic        WE, RD;
    logic [3:0]  BE;
    logic [11:0] Burst;
    logic        BurstFirst, BurstLast;
    logic [31:0] DataOut;
    logic [31:0] DataIn = '0;
    logic        WRAck, RDAck;
    logic [2:0]  Interrupt;
    logic        Update, UpdateResponse;

    int          checks = 0;
    int          passes = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          echo_en = 1'b1;
    bit          end_seen = 1'b0;
    logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
    logic [31:0] mem [logic [31:0]];
    beat_t       log_q[$];
    beat_t       exp_q[$];
    int          irq_plan[$];

    vproc #(
        .INT_WIDTH(3), .NODE_WIDTH(32), .BURST_ADDR_INCR(INCR), .DISABLE_DELTA(1'b0),
        .BASE_ADDR(BASE), .NUM_WORDS(NW), .IRQ_ADDR(IRQA), .END_ADDR(ENDA)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Addr(Addr), .WE(WE), .RD(RD), .BE(BE),
        .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast),
        .DataOut(DataOut), .DataIn(DataIn), .WRAck(WRAck), .RDAck(RDAck),
        .Interrupt(Interrupt), .Update(Update), .UpdateResponse(UpdateResponse),
        .Node(NODE_ID)
    );

    always #5 Clk = ~Clk;

    // The non-matching ack is always high, so only strobe-matched acks may count.
    assign WRAck = WE ? (wait_cnt >= ack_delay) : RD;
    assign RDAck = RD ? (wait_cnt >= ack_delay) : WE;
    assign UpdateResponse = echo_en ? Update : 1'b0;

    wire accepted = (WE && WRAck) || (RD && RDAck);

    always @(posedge Clk or posedge Reset) begin
        if (Reset) wait_cnt <= 0;
        else if ((WE || RD) && !accepted) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        logic [31:0] v;
        v = mem.exists(a) ? mem[a] : 32'h0;
        if (a == corrupt_addr) v = v ^ FLIP;
        return v;
    endfunction

    function automatic logic [84:0] outs();
        return {Addr, WE, RD, BE, Burst, BurstFirst, BurstLast, DataOut, Update};
    endfunction

    beat_t       lb;
    logic [31:0] w;
    bit          was_waiting = 1'b0;
    logic [69:0] held;

    // Logger and memory: sampled mid-cycle, where the next rising edge will see the same values.
    always @(negedge Clk) begin
        DataIn = rd_mem(Addr);
        if (Reset) begin
            was_waiting = 1'b0;
        end else begin
            if (!WE && !RD) `CHK("idle_ctl", {Burst, BurstFirst, BurstLast}, 14'd0)
            if (was_waiting) `CHK("hold_stable", {WE, RD, Addr, DataOut, BE}, held)
            if (accepted) begin
                lb.addr  = Addr;
                lb.we    = WE;
                lb.rd    = RD;
                lb.be    = WE ? BE : 4'h0;
                lb.data  = WE ? DataOut : 32'h0;
                lb.burst = Burst;
                lb.first = BurstFirst;
                lb.last  = BurstLast;
                lb.hold  = 8'(wait_cnt + 1);
                log_q.push_back(lb);
                if (WE) begin
                    w = mem.exists(Addr) ? mem[Addr] : 32'h0;
                    for (int k = 0; k < 4; k++) if (BE[k]) w[8*k +: 8] = DataOut[8*k +: 8];
                    mem[Addr] = w;
                    if (Addr == ENDA) end_seen = 1'b1;
                end
            end
            was_waiting = (WE || RD) && !accepted;
            held = {WE, RD, Addr, DataOut, BE};
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic wr, input logic [3:0] be,
                             input logic [31:0] d, input int burst, input bit first, input bit last);
        beat_t e;
        e.addr = a; e.we = wr; e.rd = !wr; e.be = be; e.data = d;
        e.burst = 12'(burst); e.first = first; e.last = last;
        e.hold = 8'(ack_delay + 1);
        exp_q.push_back(e);
    endtask

    // Reference program: pattern burst, queued IRQ reports, byte patch, read-back, error report.
    task automatic build_expected(input int corrupt_idx);
        logic [31:0] model [NW];
        logic [31:0] rdv, expv;
        int          err;
        err = 0;
        exp_q.delete();
        for (int i = 0; i < NW; i++) begin
            model[i] = {P, 16'(i)};
            push_beat(BASE + 32'(i * INCR), 1'b1, 4'hF, {P, 16'(i)}, NW, i == 0, i == NW - 1);
        end
        foreach (irq_plan[j]) push_beat(IRQA, 1'b1, 4'hF, {16'h1A00, 16'(irq_plan[j])}, 1, 1'b1, 1'b1);
        push_beat(BASE, 1'b1, 4'b0001, 32'h0000_00EE, 1, 1'b1, 1'b1);
        model[0][7:0] = 8'hEE;
        for (int i = 0; i < NW; i++) begin
            push_beat(BASE + 32'(i * INCR), 1'b0, 4'h0, 32'h0, NW, i == 0, i == NW - 1);
            rdv  = model[i] ^ ((i == corrupt_idx) ? FLIP : 32'h0);
            expv = (i == 0) ? {P, 16'h00EE} : {P, 16'(i)};
            if (rdv != expv) err++;
        end
        push_beat(ENDA, 1'b1, 4'hF, {16'h0, 16'(err)}, 1, 1'b1, 1'b1);
    endtask

    task automatic check_run(input string tag, input logic exp_upd);
        beat_t got;
        for (int n = 0; n < 600 && !end_seen; n++) @(negedge Clk);
        `CHK($sformatf("%s_end", tag), end_seen, 1'b1)
        repeat (6) @(negedge Clk);
        `CHK($sformatf("%s_done", tag), {WE, RD}, 2'b00)
        `CHK($sformatf("%s_len", tag), log_q.size(), exp_q.size())
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < log_q.size()) ? log_q[i] : '0;
            `CHK($sformatf("%s_beat%0d", tag, i), got, exp_q[i])
        end
        `CHK($sformatf("%s_upd", tag), Update, exp_upd)
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        log_q.delete();
        mem.delete();
        end_seen = 1'b0;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Interrupt = '0;
        repeat (3) @(negedge Clk);
        `CHK("reset_outs", outs(), 85'd0)

        // 1: plain program run, then interrupts must stay ignored once done
        irq_plan.delete();
        build_expected(-1);
        log_q.delete();
        Reset = 1'b0;
        check_run("t1", 1'b0);
        Interrupt = 3'b100;
        repeat (4) @(negedge Clk);
        Interrupt = '0;
        repeat (4) @(negedge Clk);
        `CHK("t1_frozen", {log_q.size(), Update, WE, RD}, {exp_q.size(), 3'b000})

        // 2: one corrupted word on read-back gives error count 1
        corrupt_addr = BASE + 32'(2 * INCR);
        do_reset();
        build_expected(2);
        check_run("t2", 1'b0);
        corrupt_addr = 32'hFFFF_FFFF;

        // 3: IRQ1 pulsed twice and IRQ0 once mid-burst: IRQ1 then IRQ0 serviced once each
        do_reset();
        irq_plan = '{1, 0};
        build_expected(-1);
        for (int n = 0; n < 100 && !(WE && Addr == BASE + 32'(INCR)); n++) @(negedge Clk);
        `CHK("t3_sync", {WE, Addr}, {1'b1, BASE + 32'(INCR)})
        Interrupt = 3'b010;
        @(negedge Clk);
        Interrupt = 3'b000;
        @(negedge Clk);
        Interrupt = 3'b011;
        @(negedge Clk);
        Interrupt = 3'b000;
        check_run("t3", 1'b0);
        irq_plan.delete();

        // 4: no echo of Update stalls after the first burst, then resumes
        echo_en = 1'b0;
        do_reset();
        build_expected(-1);
        repeat (30) @(negedge Clk);
        `CHK("t4_stall_len", log_q.size(), NW)
        `CHK("t4_stall_upd", {Update, WE, RD}, 3'b100)
        echo_en = 1'b1;
        check_run("t4", 1'b0);

        // 5: acks delayed by three cycles, every beat held four cycles
        ack_delay = 3;
        do_reset();
        build_expected(-1);
        check_run("t5", 1'b0);
        ack_delay = 0;

        // 6: asynchronous reset in the middle of the read burst, then a clean restart
        do_reset();
        for (int n = 0; n < 100 && !(RD && Addr == BASE + 32'(INCR)); n++) @(negedge Clk);
        `CHK("t6_sync", {RD, Addr}, {1'b1, BASE + 32'(INCR)})
        #2 Reset = 1'b1;
        #1 `CHK("t6_async_outs", outs(), 85'd0)
        @(negedge Clk);
        @(negedge Clk);
        log_q.delete();
        mem.delete();
        end_seen = 1'b0;
        Reset = 1'b0;
        build_expected(-1);
        check_run("t6", 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
